rw_array_clr: RTL
=================

Name: rw_array_clr

Overview:
- Parametrised successor to the small register-array used for cache tag, valid and data storage.
- Adds per-byte write masking, a registered read port with a valid strobe, and an optional write-to-read bypass.
- Adds a hardware clear engine that loads every entry with a programmable init value after reset or on request.
- Sits under cache and BTB controllers, which must wait while busy=1 before issuing reads or writes.

Parameters:
s_index, 3, index width; num_sets = 2**s_index entries
width, 32, entry width in bits; must be a multiple of 8 (elaboration-time assertion)
init_val, 32'h00000060, value written to every entry by the clear engine (truncated or zero-extended to width)
bypass, 1, 1 = a same-cycle write to the read index is forwarded to dataout; 0 = read returns pre-write contents

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
read  in  1  read request
rindex  in  s_index  read index
load  in  1  write request
windex  in  s_index  write index
datain  in  width  write data
wmask  in  width/8  byte write enables; bit i covers datain[8i+7:8i]
clear  in  1  request re-initialisation of all entries
dataout  out  width  registered read data
rvalid  out  1  high for exactly the one cycle dataout carries new read data
busy  out  1  clear engine active; read, load and clear are ignored

Behaviour:
- Reset (async, rst=1):
  - state=CLEAR, clr_ptr=0, busy=1, dataout=0, rvalid=0.
  - Array storage has no async reset; it is initialised by the clear engine.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle: data[clr_ptr] <= init_val; clr_ptr increments.
  - When clr_ptr==num_sets-1, that last write completes and state goes to IDLE next cycle.
  - busy=1 for exactly num_sets cycles after rst deassertion or after clear acceptance.
  - read, load and clear are ignored in CLEAR; dataout holds; rvalid=0.
- IDLE, clear=1:
  - Next state CLEAR, clr_ptr=0, busy=1 from the next cycle.
  - clear has priority: a load or read in the same cycle is dropped and rvalid stays 0.
- IDLE, load=1:
  - For each i with wmask[i]=1: data[windex][8i+:8] <= datain[8i+:8]. Unmasked bytes are unchanged.
  - wmask=0 is a legal no-op.
- IDLE, read=1:
  - Next edge: dataout <= data[rindex], rvalid <= 1. Latency is 1 cycle.
  - Without read, rvalid <= 0 and dataout holds its last value.
- Simultaneous read and load, rindex==windex:
  - bypass=1: dataout = merged word (datain bytes where wmask=1, old bytes elsewhere).
  - bypass=0: dataout = old word.
  - In both modes the array is updated with the write.
- Simultaneous read and load, rindex!=windex: independent, both complete.
- Back-to-back reads: one result per cycle, rvalid stays high.
- Reset asserted mid-CLEAR or mid-operation: async return to the reset state. The clear sequence restarts from entry 0 after deassertion.
- clr_ptr is s_index bits and never wraps past num_sets-1 while in CLEAR.

Test Plan:
- rst pulse, then release -> busy=1 for 8 cycles, then 0. Reading indices 0..7 back-to-back -> dataout=0x00000060 each cycle after the request, rvalid continuously high.
- load windex=3, datain=0xAABBCCDD, wmask=4'b0101 over init contents, then read 3 -> dataout=0x00BB00DD.
- bypass=1: same-cycle load windex=5, datain=0x12345678, wmask=4'b1111 with read rindex=5 -> dataout=0x12345678. Repeat with bypass=0 -> 0x00000060; a later read returns 0x12345678.
- In IDLE after writes to entries 1 and 6, assert clear together with load windex=2 -> busy 8 cycles, load dropped. All entries read back as 0x00000060.
- During busy, drive load windex=0, datain=0xFFFFFFFF and read=1 -> rvalid stays 0. After busy falls, read 0 -> 0x00000060.
- Assert rst on the 4th cycle of the post-reset clear -> dataout=0, rvalid=0 immediately. After release, busy=1 for a full 8 cycles and all entries read back 0x00000060.

Source files
------------

// File: rtl/rw_array_clr.sv
// Register array with byte-masked writes, registered read port and a
// hardware clear engine that loads init_val into every entry.
module rw_array_clr #(
  parameter int unsigned s_index  = 3,
  parameter int unsigned width    = 32,
  parameter logic [31:0] init_val = 32'h00000060,
  parameter bit          bypass   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic [s_index-1:0] rindex,
  input  logic               load,
  input  logic [s_index-1:0] windex,
  input  logic [width-1:0]   datain,
  input  logic [width/8-1:0] wmask,
  input  logic               clear,
  output logic [width-1:0]   dataout,
  output logic               rvalid,
  output logic               busy
);

  localparam int unsigned num_sets = 2 ** s_index;
  localparam int unsigned nbytes   = width / 8;
  localparam logic [width-1:0]   init_w = width'(init_val);
  localparam logic [s_index-1:0] last   = '1;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  if (width % 8 != 0) begin : g_width_chk
    $error("rw_array_clr: width must be a multiple of 8");
  end

  logic [0:0]         state;
  logic [s_index-1:0] clr_ptr;
  logic [width-1:0]   data [num_sets];
  logic [width-1:0]   merged;
  logic               wr_en;

  assign busy  = (state == CLEAR);
  assign wr_en = (state == IDLE) && !clear && load;

  // Write word as it will look after the masked update.
  always_comb begin
    merged = data[windex];
    for (int i = 0; i < nbytes; i++) begin
      if (wmask[i]) merged[8*i +: 8] = datain[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) data[clr_ptr] <= init_w;
    else if (wr_en)     data[windex]  <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      dataout <= '0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      unique case (state)
        CLEAR: begin
          if (clr_ptr == last) state <= IDLE;
          else clr_ptr <= clr_ptr + 1'b1;
        end
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end else if (read) begin
            rvalid <= 1'b1;
            if (bypass && load && rindex == windex)
              dataout <= merged;
            else
              dataout <= data[rindex];
          end
        end
      endcase
    end
  end

endmodule
